// File: rtl/adc_capture_buf.sv
// adc_capture_buf
// Trigger-and-capture stage on the 12-bit two's complement ADC sample bus.
// After an arm pulse it waits for a trigger (level crossing, forced, or
// immediate) and writes a decimated burst of 2**ADDR_W samples into an
// external single-port sample RAM. The RAM is read back later by the SoC.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, nothing captured yet; waits for arm
// ARMED   | fresh burst prepared; waits for trigger hit
// CAPTURE | storing one sample every decim_l+1 cycles
// DONE    | full burst written; waits for the next arm
module adc_capture_buf #(
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 10,
  parameter int DECIM_W = 8
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] adc_data,
  input  logic                     arm,
  input  logic                     force_trig,
  input  logic                     trig_en,
  input  logic signed [DATA_W-1:0] trig_level,
  input  logic        [DECIM_W-1:0] decim,
  output logic                     buf_wr,
  output logic        [ADDR_W-1:0] buf_addr,
  output logic        [DATA_W-1:0] buf_data,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0]  LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DECIM_W-1:0] DCNT_ONE  = {{(DECIM_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  // sample pipe: s_q is the newest registered sample, s_prev the one before
  logic signed [DATA_W-1:0] s_q, s_prev;

  logic [ADDR_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [DECIM_W-1:0] dcnt, dcnt_nxt;
  logic [DECIM_W-1:0] decim_l, decim_l_nxt;

  logic               buf_wr_nxt;
  logic [ADDR_W-1:0]  buf_addr_nxt;
  logic [DATA_W-1:0]  buf_data_nxt;

  logic               level_cross;
  logic               hit;

  // free-running input pipe, never gated so the crossing detector always
  // sees two consecutive samples
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      s_prev <= '0;
    end else begin
      s_prev <= s_q;
      s_q    <= adc_data;
    end
  end

  // rising crossing of the signed threshold, or an unconditional trigger
  always_comb begin
    level_cross = (s_prev < trig_level) && (s_q >= trig_level);
    hit         = force_trig | ~trig_en | (trig_en & level_cross);
  end

  // state, pointer, decimation counter and RAM write port registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      dcnt     <= '0;
      decim_l  <= '0;
      buf_wr   <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      dcnt     <= dcnt_nxt;
      decim_l  <= decim_l_nxt;
      buf_wr   <= buf_wr_nxt;
      buf_addr <= buf_addr_nxt;
      buf_data <= buf_data_nxt;
    end
  end

  // next-state and datapath decisions; address/data hold unless writing
  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    dcnt_nxt     = dcnt;
    decim_l_nxt  = decim_l;
    buf_wr_nxt   = 1'b0;
    buf_addr_nxt = buf_addr;
    buf_data_nxt = buf_data;

    case (state)
      IDLE: begin
        if (arm) begin
          state_nxt  = ARMED;
          wr_ptr_nxt = '0;
          dcnt_nxt   = '0;
        end
      end

      ARMED: begin
        if (hit) begin
          // trigger sample goes to address 0; ratio frozen for the burst
          state_nxt    = CAPTURE;
          buf_wr_nxt   = 1'b1;
          buf_addr_nxt = '0;
          buf_data_nxt = s_q;
          wr_ptr_nxt   = ADDR_ONE;
          dcnt_nxt     = '0;
          decim_l_nxt  = decim;
        end
      end

      CAPTURE: begin
        if (dcnt == decim_l) begin
          buf_wr_nxt   = 1'b1;
          buf_addr_nxt = wr_ptr;
          buf_data_nxt = s_q;
          wr_ptr_nxt   = wr_ptr + ADDR_ONE;
          dcnt_nxt     = '0;
          if (wr_ptr == LAST_ADDR) begin
            state_nxt = DONE;
          end
        end else begin
          dcnt_nxt = dcnt + DCNT_ONE;
        end
      end

      DONE: begin
        if (arm) begin
          state_nxt  = ARMED;
          wr_ptr_nxt = '0;
          dcnt_nxt   = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // status decoded straight from the state so reset clears it at once
  always_comb begin
    busy = (state == ARMED) || (state == CAPTURE);
    done = (state == DONE);
  end

endmodule
